// File: rtl/conf_int_mul_acc_stage.sv
// conf_int_mul_acc_stage: saturating burst accumulator for multiplier products.
// Sums len products per burst and holds the result until the consumer takes it.
module conf_int_mul_acc_stage #(
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int ACC_BITWIDTH = 72,
  parameter int LEN_BITWIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [2*DATA_PATH_BITWIDTH-1:0] prod,
  input  logic acc__sel,
  input  logic in_valid,
  output logic in_ready,
  input  logic [LEN_BITWIDTH-1:0] len,
  input  logic clear,
  output logic [ACC_BITWIDTH-1:0] acc_out,
  output logic out_valid,
  input  logic out_ready,
  output logic out_apx,
  output logic ovf
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, next;
  logic [LEN_BITWIDTH-1:0] remaining;
  logic [ACC_BITWIDTH:0] sum;
  logic accept;
  assign in_ready = state != DONE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready && !clear;
  // Extra top bit of sum is the unsigned carry that triggers saturation.
  assign sum = {1'b0, acc_out} + (ACC_BITWIDTH+1)'(prod);
  always_comb begin
    next = state;
    if (clear) next = IDLE;
    else if (state == IDLE && accept) next = (len <= LEN_BITWIDTH'(1)) ? DONE : ACCUM;
    else if (state == ACCUM && accept) next = (remaining == LEN_BITWIDTH'(1)) ? DONE : ACCUM;
    else if (state == DONE && out_ready) next = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc_out <= '0;
      remaining <= '0;
      out_apx <= 1'b0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc_out <= '0;
      remaining <= '0;
      out_apx <= 1'b0;
      ovf <= 1'b0;
    end else if (accept && state == IDLE) begin
      acc_out <= ACC_BITWIDTH'(prod);
      remaining <= (len == '0) ? '0 : len - LEN_BITWIDTH'(1);
      out_apx <= ~acc__sel;
      ovf <= 1'b0;
    end else if (accept && state == ACCUM) begin
      acc_out <= sum[ACC_BITWIDTH] ? '1 : sum[ACC_BITWIDTH-1:0];
      remaining <= remaining - LEN_BITWIDTH'(1);
      out_apx <= out_apx | ~acc__sel;
      ovf <= ovf | sum[ACC_BITWIDTH];
    end
endmodule

// File: tb/tb_conf_int_mul_acc_stage.sv
// tb_conf_int_mul_acc_stage: directed checks of the burst accumulator, default and 64-bit accumulator builds.
module tb_conf_int_mul_acc_stage;
  logic clk = 0, rst = 0;
  logic [63:0] prod = '0;
  logic acc__sel = 1, in_valid = 0, clear = 0, out_ready = 1;
  logic [7:0] len = '0;
  logic in_ready, out_valid, out_apx, ovf;
  logic [71:0] acc_out;
  logic in_ready_b, out_valid_b, out_apx_b, ovf_b;
  logic [63:0] acc_out_b;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  conf_int_mul_acc_stage dut (
    .clk(clk), .rst(rst), .prod(prod), .acc__sel(acc__sel), .in_valid(in_valid),
    .in_ready(in_ready), .len(len), .clear(clear), .acc_out(acc_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_apx(out_apx), .ovf(ovf)
  );

  conf_int_mul_acc_stage #(.ACC_BITWIDTH(64)) dut_b (
    .clk(clk), .rst(rst), .prod(prod), .acc__sel(acc__sel), .in_valid(in_valid),
    .in_ready(in_ready_b), .len(len), .clear(clear), .acc_out(acc_out_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_apx(out_apx_b), .ovf(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (acc_out !== 72'h0) begin n_fail++; $display("FAIL reset_acc: got %h want 0", acc_out); end
    n_checks++; if ({out_apx, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {out_apx, ovf}); end
    @(negedge clk);
    rst = 1;
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1; acc__sel = 1;
    in_valid = 1; prod = 64'd10; len = 8'd3;
    tick();
    prod = 64'd20; len = 8'd0;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_mid_valid: got %b want 0", out_valid); end
    prod = 64'd30;
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_checks++; if (acc_out !== 72'd60) begin n_fail++; $display("FAIL basic_acc: got %0d want 60", acc_out); end
    n_checks++; if ({out_apx, ovf} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b want 00", {out_apx, ovf}); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_done: got %b want 0", in_ready); end
    tick();
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL basic_back_idle: got %b want 10", {in_ready, out_valid}); end
  endtask

  task automatic test_one_beat();
    in_valid = 1; prod = 64'hFFFF_FFFF_FFFF_0000; acc__sel = 0; len = 8'd0;
    tick();
    in_valid = 0; acc__sel = 1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL one_beat_valid: got %b want 1", out_valid); end
    n_checks++; if (acc_out !== 72'h00_FFFF_FFFF_FFFF_0000) begin n_fail++; $display("FAIL one_beat_acc: got %h want 00ffffffffffff0000", acc_out); end
    n_checks++; if ({out_apx, ovf} !== 2'b10) begin n_fail++; $display("FAIL one_beat_flags: got %b want 10", {out_apx, ovf}); end
    tick();
  endtask

  task automatic test_saturate();
    in_valid = 1; prod = 64'hFFFF_FFFF_FFFF_FFFF; len = 8'd2;
    tick();
    prod = 64'd5;
    tick();
    in_valid = 0;
    n_checks++; if (out_valid_b !== 1'b1) begin n_fail++; $display("FAIL sat_valid: got %b want 1", out_valid_b); end
    n_checks++; if (acc_out_b !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL sat_acc: got %h want ffffffffffffffff", acc_out_b); end
    n_checks++; if (ovf_b !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b want 1", ovf_b); end
    n_checks++; if (acc_out !== 72'h01_0000_0000_0000_0004) begin n_fail++; $display("FAIL wide_no_sat_acc: got %h want 010000000000000004", acc_out); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL wide_no_sat_ovf: got %b want 0", ovf); end
    tick();
    in_valid = 1; prod = 64'd1; len = 8'd2;
    tick();
    n_checks++; if ({ovf_b, out_valid_b} !== 2'b00) begin n_fail++; $display("FAIL sat_ovf_cleared: got %b want 00", {ovf_b, out_valid_b}); end
    tick();
    in_valid = 0;
    n_checks++; if (acc_out_b !== 64'd2) begin n_fail++; $display("FAIL sat_next_acc: got %0d want 2", acc_out_b); end
    tick();
  endtask

  task automatic test_clear();
    in_valid = 1; prod = 64'd3; len = 8'd4;
    tick();
    tick();
    clear = 1; prod = 64'd100;
    tick();
    clear = 0; in_valid = 0;
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL clear_state: got %b want 10", {in_ready, out_valid}); end
    n_checks++; if (acc_out !== 72'd0) begin n_fail++; $display("FAIL clear_acc: got %0d want 0", acc_out); end
    in_valid = 1; prod = 64'd7; len = 8'd1;
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clear_next_valid: got %b want 1", out_valid); end
    n_checks++; if (acc_out !== 72'd7) begin n_fail++; $display("FAIL clear_next_acc: got %0d want 7", acc_out); end
    tick();
  endtask

  task automatic test_hold();
    out_ready = 0;
    in_valid = 1; prod = 64'd42; len = 8'd1;
    tick();
    prod = 64'd99;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({in_ready, out_valid} !== 2'b01) begin n_fail++; $display("FAIL hold_hs_%0d: got %b want 01", i, {in_ready, out_valid}); end
      n_checks++; if (acc_out !== 72'd42) begin n_fail++; $display("FAIL hold_acc_%0d: got %0d want 42", i, acc_out); end
      tick();
    end
    out_ready = 1; in_valid = 0;
    tick();
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL hold_release: got %b want 10", {in_ready, out_valid}); end
    n_checks++; if (acc_out !== 72'd42) begin n_fail++; $display("FAIL hold_no_consume: got %0d want 42", acc_out); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1; prod = 64'd5; len = 8'd3;
    tick();
    in_valid = 0;
    #2 rst = 0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    n_checks++; if (acc_out !== 72'd0) begin n_fail++; $display("FAIL rst_mid_acc: got %0d want 0", acc_out); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
    #2 rst = 1;
    tick();
    in_valid = 1; prod = 64'd1; len = 8'd2;
    tick();
    tick();
    in_valid = 0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_after_valid: got %b want 1", out_valid); end
    n_checks++; if (acc_out !== 72'd2) begin n_fail++; $display("FAIL rst_after_acc: got %0d want 2", acc_out); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_one_beat();
    test_saturate();
    test_clear();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
